// File: rtl/btb_update_ctrl.sv
// BTB write-port owner: flags mispredicts, queues (PC, NPC) updates and
// drains them one per cycle, and runs a full-table neutralising sweep on request.
module btb_update_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BTB_SIZE   = 256,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             resolve_valid,
  input  logic [15:0]      resolve_pc,
  input  logic [15:0]      resolve_npc_pred,
  input  logic [15:0]      resolve_npc_actual,
  input  logic             clear_req,
  output logic             flush,
  output logic [15:0]      redirect_pc,
  output logic             btb_we,
  output logic [15:0]      btb_pc,
  output logic [15:0]      btb_npc,
  output logic             sweep_busy,
  output logic [CNT_W-1:0] mispredict_cnt,
  output logic [7:0]       drop_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned IW = $clog2(BTB_SIZE);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [IW-1:0] idx;
  logic [15:0]   q_pc  [FIFO_DEPTH];
  logic [15:0]   q_npc [FIFO_DEPTH];

  logic mp_c, empty_c, full_c, pop_c, push_c, drop_c;
  logic [15:0] sweep_pc_c;

  // Queue control: pops only in IDLE; a clear request supersedes both push and pop.
  always_comb begin
    mp_c       = resolve_valid && (resolve_npc_pred != resolve_npc_actual);
    empty_c    = (wr_ptr == rd_ptr);
    full_c     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop_c      = (state == IDLE) && !empty_c && !clear_req;
    push_c     = (state == IDLE) && mp_c && !clear_req && (!full_c || pop_c);
    drop_c     = mp_c && !push_c;
    sweep_pc_c = 16'({idx, 2'b00});
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clear_req) state_nxt = SWEEP;
      SWEEP:   if (idx == IW'(BTB_SIZE - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Queue storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_c) begin
      q_pc[wr_ptr[AW-1:0]]  <= resolve_pc;
      q_npc[wr_ptr[AW-1:0]] <= resolve_npc_actual;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush          <= 1'b0;
      redirect_pc    <= '0;
      btb_we         <= 1'b0;
      btb_pc         <= '0;
      btb_npc        <= '0;
      sweep_busy     <= 1'b0;
      mispredict_cnt <= '0;
      drop_cnt       <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      idx            <= '0;
    end else begin
      flush      <= mp_c;
      btb_we     <= 1'b0;
      sweep_busy <= 1'b0;
      if (mp_c) redirect_pc <= resolve_npc_actual;
      if (mp_c && (mispredict_cnt != '1)) mispredict_cnt <= mispredict_cnt + CNT_W'(1);
      if (drop_c && (drop_cnt != '1))     drop_cnt <= drop_cnt + 8'(1);
      case (state)
        IDLE: begin
          if (clear_req) begin
            rd_ptr <= wr_ptr;
            idx    <= '0;
          end else begin
            if (push_c) wr_ptr <= wr_ptr + PW'(1);
            if (pop_c) begin
              rd_ptr  <= rd_ptr + PW'(1);
              btb_we  <= 1'b1;
              btb_pc  <= q_pc[rd_ptr[AW-1:0]];
              btb_npc <= q_npc[rd_ptr[AW-1:0]];
            end
          end
        end
        SWEEP: begin
          // Writing NPC = PC+4 makes a hit indistinguishable from a miss.
          btb_we     <= 1'b1;
          sweep_busy <= 1'b1;
          btb_pc     <= sweep_pc_c;
          btb_npc    <= sweep_pc_c + 16'd4;
          idx        <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed-vector bench for btb_update_ctrl with hand-computed expectations.
module tb_btb_update_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        resolve_valid;
  logic [15:0] resolve_pc, resolve_npc_pred, resolve_npc_actual;
  logic        clear_req;
  logic        flush;
  logic [15:0] redirect_pc;
  logic        btb_we;
  logic [15:0] btb_pc, btb_npc;
  logic        sweep_busy;
  logic [15:0] mispredict_cnt;
  logic [7:0]  drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  btb_update_ctrl dut (
    .clk(clk), .rst(rst),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
    .resolve_npc_pred(resolve_npc_pred), .resolve_npc_actual(resolve_npc_actual),
    .clear_req(clear_req),
    .flush(flush), .redirect_pc(redirect_pc),
    .btb_we(btb_we), .btb_pc(btb_pc), .btb_npc(btb_npc),
    .sweep_busy(sweep_busy), .mispredict_cnt(mispredict_cnt), .drop_cnt(drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic v, input logic [15:0] pc, input logic [15:0] pred,
                         input logic [15:0] act);
    resolve_valid      = v;
    resolve_pc         = pc;
    resolve_npc_pred   = pred;
    resolve_npc_actual = act;
  endtask

  initial begin
    rst = 1'b1;
    clear_req = 1'b0;
    resolve(1'b0, 16'h0, 16'h0, 16'h0);
    step();
    step();
    check("rst_flush", 32'(flush), 32'h0);
    check("rst_redir", 32'(redirect_pc), 32'h0);
    check("rst_we", 32'(btb_we), 32'h0);
    check("rst_pc", 32'(btb_pc), 32'h0);
    check("rst_npc", 32'(btb_npc), 32'h0);
    check("rst_busy", 32'(sweep_busy), 32'h0);
    check("rst_mpc", 32'(mispredict_cnt), 32'h0);
    check("rst_drop", 32'(drop_cnt), 32'h0);
    rst = 1'b0;
    step();

    // Single mispredict: flush at N+1, BTB write at N+2
    resolve(1'b1, 16'h0040, 16'h0044, 16'h0100);
    step();
    resolve(1'b0, 16'h0, 16'h0, 16'h0);
    check("mp1_flush", 32'(flush), 32'h1);
    check("mp1_redir", 32'(redirect_pc), 32'h0100);
    check("mp1_we_early", 32'(btb_we), 32'h0);
    step();
    check("mp1_flush_pulse", 32'(flush), 32'h0);
    check("mp1_we", 32'(btb_we), 32'h1);
    check("mp1_pc", 32'(btb_pc), 32'h0040);
    check("mp1_npc", 32'(btb_npc), 32'h0100);
    check("mp1_cnt", 32'(mispredict_cnt), 32'h1);
    step();
    check("mp1_we_off", 32'(btb_we), 32'h0);

    // Correct prediction
    resolve(1'b1, 16'h0080, 16'h0044, 16'h0044);
    step();
    resolve(1'b0, 16'h0, 16'h0, 16'h0);
    check("ok_flush", 32'(flush), 32'h0);
    check("ok_redir_hold", 32'(redirect_pc), 32'h0100);
    step();
    check("ok_we", 32'(btb_we), 32'h0);
    check("ok_cnt", 32'(mispredict_cnt), 32'h1);

    // Back-to-back burst of 6
    for (int i = 0; i < 6; i++) begin
      resolve(1'b1, 16'(16'h0200 + 4 * i), 16'h0000, 16'(16'h1000 + 16 * i));
      step();
      check("burst_flush", 32'(flush), 32'h1);
      check("burst_redir", 32'(redirect_pc), 32'(16'h1000 + 16 * i));
      if (i > 0) begin
        check("burst_we", 32'(btb_we), 32'h1);
        check("burst_pc", 32'(btb_pc), 32'(16'h0200 + 4 * (i - 1)));
        check("burst_npc", 32'(btb_npc), 32'(16'h1000 + 16 * (i - 1)));
      end
    end
    resolve(1'b0, 16'h0, 16'h0, 16'h0);
    step();
    check("burst_flush_end", 32'(flush), 32'h0);
    check("burst_we_last", 32'(btb_we), 32'h1);
    check("burst_pc_last", 32'(btb_pc), 32'h0214);
    check("burst_npc_last", 32'(btb_npc), 32'h1050);
    step();
    check("burst_we_off", 32'(btb_we), 32'h0);
    check("burst_cnt", 32'(mispredict_cnt), 32'h7);
    check("burst_drop", 32'(drop_cnt), 32'h0);

    // Sweep with a queued entry that must be discarded uncounted
    resolve(1'b1, 16'h0300, 16'h0000, 16'h2000);
    step();
    resolve(1'b0, 16'h0, 16'h0, 16'h0);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    check("clr_we", 32'(btb_we), 32'h0);
    check("clr_busy", 32'(sweep_busy), 32'h0);
    for (int k = 0; k < 256; k++) begin
      if (k == 50) clear_req = 1'b1;
      if (k == 100) resolve(1'b1, 16'h0500, 16'h0000, 16'h3000);
      step();
      clear_req = 1'b0;
      resolve(1'b0, 16'h0, 16'h0, 16'h0);
      check("sw_we", 32'(btb_we), 32'h1);
      check("sw_busy", 32'(sweep_busy), 32'h1);
      check("sw_pc", 32'(btb_pc), 32'(k * 4));
      check("sw_npc", 32'(btb_npc), 32'(k * 4 + 4));
      if (k == 100) begin
        check("sw_mp_flush", 32'(flush), 32'h1);
        check("sw_mp_redir", 32'(redirect_pc), 32'h3000);
      end
    end
    step();
    check("sw_done_we", 32'(btb_we), 32'h0);
    check("sw_done_busy", 32'(sweep_busy), 32'h0);
    check("sw_drop", 32'(drop_cnt), 32'h1);
    check("sw_cnt", 32'(mispredict_cnt), 32'h9);

    // Back in IDLE: normal update works again
    resolve(1'b1, 16'h0600, 16'h0604, 16'h0700);
    step();
    resolve(1'b0, 16'h0, 16'h0, 16'h0);
    step();
    check("post_we", 32'(btb_we), 32'h1);
    check("post_pc", 32'(btb_pc), 32'h0600);
    check("post_npc", 32'(btb_npc), 32'h0700);

    // clear_req and mispredict together: sweep wins, update dropped
    resolve(1'b1, 16'h0800, 16'h0000, 16'h0900);
    clear_req = 1'b1;
    step();
    resolve(1'b0, 16'h0, 16'h0, 16'h0);
    clear_req = 1'b0;
    check("cm_flush", 32'(flush), 32'h1);
    check("cm_redir", 32'(redirect_pc), 32'h0900);
    check("cm_we", 32'(btb_we), 32'h0);
    check("cm_drop", 32'(drop_cnt), 32'h2);
    check("cm_cnt", 32'(mispredict_cnt), 32'hB);
    for (int k = 0; k < 128; k++) step();
    check("mid_pc", 32'(btb_pc), 32'h01FC);
    check("mid_busy", 32'(sweep_busy), 32'h1);

    // Reset mid-sweep at idx 0x80
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_we", 32'(btb_we), 32'h0);
    check("mrst_busy", 32'(sweep_busy), 32'h0);
    check("mrst_cnt", 32'(mispredict_cnt), 32'h0);
    check("mrst_drop", 32'(drop_cnt), 32'h0);
    check("mrst_redir", 32'(redirect_pc), 32'h0);
    step();
    check("mrst_we2", 32'(btb_we), 32'h0);
    check("mrst_busy2", 32'(sweep_busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
